// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the Gray-to-binary conversion scheduler.
//   gcs_state_e : controller states (IDLE, CONV, DONE)
//   gcs_idw()   : requester-ID width derived from the requester count
package gray_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } gcs_state_e;

  // One ID bit minimum so a single-requester build still has a legal port.
  function automatic int gcs_idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/gcs_arbiter.sv
// Request arbiter for the Gray conversion scheduler.
// Build option GCS_ROUND_ROBIN_EN:
//   defined   - round-robin search starting at an internal pointer, wrapping
//               NREQ-1 -> 0; the pointer moves to winner+1 on every grant.
//   undefined - fixed priority, lowest asserted index wins; no pointer state.
// Ports:
//   clk, rst   clock and async active-high reset (round-robin build only)
//   i_advance  a grant is being taken this cycle (round-robin build only)
//   i_req      request vector
//   o_grant    one-hot grant (all zero when no request)
//   o_idx      encoded index of the winner
//   o_any      at least one request is present
module gcs_arbiter
  import gray_conv_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = gcs_idw(NREQ)
) (
`ifdef GCS_ROUND_ROBIN_EN
  input  logic            clk,
  input  logic            rst,
  input  logic            i_advance,
`endif
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

`ifdef GCS_ROUND_ROBIN_EN
  logic [IDW-1:0]    r_ptr;
  logic [2*NREQ-1:0] w_req2;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic [IDW:0]      w_sum;

  // Rotate the request vector so the pointer position sits at bit 0; the
  // first set bit of the rotated vector is then the round-robin winner.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = NREQ'(w_req2 >> r_ptr);

  always_comb begin
    w_off = '0;
    o_any = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        w_off = IDW'(off);
        o_any = 1'b1;
      end
    end
    // Undo the rotation: winner = (ptr + off) mod NREQ.
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IDW+1)'(NREQ)) begin
      w_sum = w_sum - (IDW+1)'(NREQ);
    end
    o_idx   = w_sum[IDW-1:0];
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_idx == IDW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end
`else
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    // Descending scan so the lowest asserted index is the last writer.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDW'(i);
        o_any = 1'b1;
      end
    end
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end
`endif

endmodule

// File: rtl/gray_conv_scheduler.sv
// Shares one bit-serial Gray-to-binary engine among NREQ requesters.
// A granted Gray word is resolved MSB-first, one bit per clock
// (b[i] = b[i+1] ^ g[i]); the result and the requester ID are presented on a
// valid/ready channel. Build option GCS_ROUND_ROBIN_EN selects round-robin
// arbitration (fixed lowest-index priority otherwise).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid[NREQ]       per-requester request
//   req_gray[NREQ*WIDTH]  Gray words, requester i at [i*WIDTH +: WIDTH]
//   req_ready[NREQ]       one-hot acceptance strobe (IDLE only)
//   out_valid/out_ready   result handshake
//   out_bin[WIDTH]        binary result (unresolved bits read 0 while busy)
//   out_id[IDW]           requester that owns out_bin
//   busy                  controller is not idle
module gray_conv_scheduler
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = gcs_idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // First bit resolved in CONV is the one just below the MSB.
  localparam logic [KW-1:0] K_START = KW'((WIDTH > 1) ? WIDTH - 2 : 0);

  gcs_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_gray, r_bin, w_bin_step, w_gray_sel;
  logic [KW-1:0]    r_k;
  logic [IDW-1:0]   r_id;
  logic             r_out_valid;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_idx;
  logic             w_any, w_take;

  assign w_take = (r_state == IDLE) && w_any;

  gcs_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
`ifdef GCS_ROUND_ROBIN_EN
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_take),
`endif
    .i_req     (req_valid),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  // Grant is one-hot, so OR-ing the masked words selects the winner's word.
  always_comb begin
    w_gray_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gray_sel = w_gray_sel | req_gray[i*WIDTH +: WIDTH];
    end
  end

  // Resolve bit r_k from the already-resolved bit above it.
  always_comb begin
    w_bin_step = r_bin;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (r_k == KW'(i)) w_bin_step[i] = r_bin[i+1] ^ r_gray[i];
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_take ? w_grant : '0;
        if (w_any) w_state_next = (WIDTH > 1) ? CONV : DONE;
      end
      CONV: if (r_k == '0) w_state_next = DONE;
      DONE: if (r_out_valid && out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gray      <= '0;
      r_bin       <= '0;
      r_k         <= '0;
      r_id        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (w_any) begin
          r_gray <= w_gray_sel;
          // MSB of binary equals MSB of Gray; lower bits start cleared.
          r_bin  <= w_gray_sel & (WIDTH'(1) << (WIDTH - 1));
          r_k    <= K_START;
          r_id   <= w_idx;
        end
        CONV: begin
          r_bin <= w_bin_step;
          r_k   <= r_k - 1'b1;
        end
        // out_valid rises on the first DONE cycle, which places it WIDTH
        // edges after the grant, and drops with the handshake.
        DONE: r_out_valid <= !(r_out_valid && out_ready);
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_bin   = r_bin;
  assign out_id    = r_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_gray_conv_scheduler.sv
module tb_gray_conv_scheduler;

  localparam int W = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_gray;
  logic           out_valid, out_ready, busy;
  logic [W-1:0]   out_bin;
  logic [1:0]     out_id;

  logic s_valid, s_ready, s_gray, s_ovalid, s_obin, s_oid, s_oready, s_busy;

  int n_pass  = 0;
  int n_total = 0;
`ifdef GCS_ROUND_ROBIN_EN
  int rr_ptr = 0;
`endif

  gray_conv_scheduler #(.WIDTH(W), .NREQ(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  gray_conv_scheduler #(.WIDTH(1), .NREQ(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (s_valid),
    .req_gray  (s_gray),
    .req_ready (s_ready),
    .out_valid (s_ovalid),
    .out_bin   (s_obin),
    .out_id    (s_oid),
    .out_ready (s_oready),
    .busy      (s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic int pick(input logic [N-1:0] v);
`ifdef GCS_ROUND_ROBIN_EN
    for (int off = 0; off < N; off++) if (v[(rr_ptr + off) % N]) return (rr_ptr + off) % N;
`else
    for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  // One full transaction starting in IDLE at posedge+1.
  task automatic do_xact(input logic [N-1:0] v, input logic [N*W-1:0] g, input int hold);
    int win;
    logic [W-1:0] gw, exp_b, mask;
    req_valid = v;
    req_gray  = g;
    out_ready = 1'b0;
    win   = pick(v);
    gw    = g[win*W +: W];
    exp_b = g2b(gw);
    #1;
    check("grant_ready", 32'(req_ready), 32'(N'(1) << win));
    check("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
`ifdef GCS_ROUND_ROBIN_EN
    rr_ptr = (win + 1) % N;
`endif
    // After the j-th edge from the grant, the top j+1 bits are resolved.
    for (int j = 0; j < W; j++) begin
      mask = ~((W'(1) << (W - 1 - j)) - W'(1));
      check("conv_bin", 32'(out_bin), 32'(exp_b & mask));
      check("conv_valid", 32'(out_valid), 0);
      check("conv_busy", 32'(busy), 1);
      check("conv_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    for (int c = 0; c <= hold; c++) begin
      check("done_valid", 32'(out_valid), 1);
      check("done_bin", 32'(out_bin), 32'(exp_b));
      check("done_id", 32'(out_id), 32'(win));
      check("done_ready", 32'(req_ready), 0);
      check("done_busy", 32'(busy), 1);
      if (c < hold) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 0);
    check("post_busy", 32'(busy), 0);
    $display("xact valid=%b gray=%h win=%0d bin=%h hold=%0d", v, g, win, exp_b, hold);
  endtask

  initial begin
    logic [N*W-1:0] gv;
    rst = 1'b1;
    req_valid = '0; req_gray = '0; out_ready = 1'b0;
    s_valid = 1'b0; s_gray = 1'b0; s_oready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_bin", 32'(out_bin), 0);
    check("rst_id", 32'(out_id), 0);
    check("rst_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request and back-pressure.
    do_xact(4'b0001, 16'h000B, 0);
    do_xact(4'b0100, 16'h0600, 10);

    // Reset in the middle of a conversion on requester 3.
    req_valid = 4'b1000; req_gray = 16'hF000; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mr_pre_busy", 32'(busy), 1);
    check("mr_pre_bin", 32'(out_bin), 32'(g2b(4'hF) & 4'b1100));
    check("mr_pre_id", 32'(out_id), 3);
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(out_valid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_bin", 32'(out_bin), 0);
    check("mr_id", 32'(out_id), 0);
    $display("xact reset mid-conversion");
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
`ifdef GCS_ROUND_ROBIN_EN
    rr_ptr = 0;
`endif

    // Contention: all four requesters hold valid.
    for (int t = 0; t < 5; t++) do_xact(4'b1111, N*W'($urandom), 0);

    // Every Gray code on every requester, noise on the others.
    for (int r = 0; r < N; r++) begin
      for (int g = 0; g < 16; g++) begin
        gv = N*W'($urandom);
        gv[r*W +: W] = W'(g);
        do_xact(N'(1) << r, gv, 0);
      end
    end

    // Random request patterns and back-pressure lengths.
    for (int t = 0; t < 40; t++) begin
      do_xact(N'($urandom_range(1, 15)), N*W'($urandom), $urandom_range(0, 3));
    end
    req_valid = '0;

    // WIDTH = 1, NREQ = 1 instance.
    for (int t = 0; t < 2; t++) begin
      s_gray  = (t == 0) ? 1'b1 : 1'b0;
      s_valid = 1'b1;
      #1;
      check("w1_ready", 32'(s_ready), 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("w1_valid_lo", 32'(s_ovalid), 0);
      check("w1_busy", 32'(s_busy), 1);
      @(posedge clk); #1;
      check("w1_valid", 32'(s_ovalid), 1);
      check("w1_bin", 32'(s_obin), 32'(s_gray));
      check("w1_id", 32'(s_oid), 0);
      s_oready = 1'b1;
      @(posedge clk); #1;
      s_oready = 1'b0;
      check("w1_post_valid", 32'(s_ovalid), 0);
      check("w1_post_busy", 32'(s_busy), 0);
      $display("xact w1 gray=%b", s_gray);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
